gbt_link_checker: RTL and testbench
===================================

# gbt_link_checker

Parametrised GBT link pattern generator and checker for the XU5 GBT data path, operating in the 40 MHz frame clock domain next to `gbt_xu5`. It drives a deterministic test pattern into the TX frame and checks the RX frame. It self-synchronises to the incoming stream, tracks lock with a hysteresis state machine, and accumulates saturating word- and bit-error counters. It replaces ad-hoc loopback checks and is used for link verification in the lab and in simulation.

## Interface
Parameters:
- `W`, 80: frame data width in bits; any value ≥ 8.
- `LOCK_GOOD`, 16: consecutive matching words needed to declare lock.
- `UNLOCK_BAD`, 4: consecutive mismatching words needed to drop lock.
- `CNT_W`, 32: width of the error counters.

Ports:
- `ClkRs_ix`, input, `ckrs_t`: one clock (`.clk`) and asynchronous active-high reset (`.reset`).
- `Mode_ib`, input, 2: pattern mode. 0 = off, 1 = counter, 2 = PRBS7, 3 = off.
- `TxEn_i`, input, 1: TX frame strobe; the generator advances on each cycle where it is high.
- `InjectError_i`, input, 1: single-cycle request to invert bit 0 of the next generated word.
- `TxData_ob`, output, W: generated frame.
- `RxData_ib`, input, W: received frame.
- `RxValid_i`, input, 1: `RxData_ib` is valid this cycle.
- `Clear_i`, input, 1: synchronous clear of both error counters.
- `Locked_o`, output, 1: checker is in LOCKED.
- `LinkLost_o`, output, 1: one-cycle pulse on the LOCKED→SEED transition.
- `WordErrors_ob`, output, CNT_W: count of mismatching words while LOCKED, saturating.
- `BitErrors_ob`, output, CNT_W: count of mismatching bits while LOCKED, saturating.

## Operation
- Generator state:
  - Counter mode: W-bit value that increments by 1 and wraps from 2^W−1 to 0.
  - PRBS7 mode: 7-bit LFSR with polynomial x^7+x^6+1, advanced W bits per word. Word MSB is the first generated bit.
  - Off mode: TxData = 0.
- Generator reload: on any change of `Mode_ib`, the counter reloads to 0 and the LFSR to 7'h7F.
- Error injection: `InjectError_i` is latched. It is applied to the next word generated with `TxEn_i`=1 and then clears. Only the output word is inverted; the generator state is unaffected.
- `next(x)`:
  - Counter mode: x+1 mod 2^W.
  - PRBS7 mode: the W bits that follow, seeded from the 7 LSBs of x.
- Checker FSM, evaluated only on cycles with `RxValid_i`=1:
  - IDLE: entered when mode is off. Counters hold. The FSM goes to SEED when mode becomes 1 or 2.
  - SEED: expected ← next(RxData), good ← 0, then go to CHECK.
  - CHECK:
    - On match: good++, expected ← next(expected). When good reaches LOCK_GOOD, go to LOCKED.
    - On mismatch: go to SEED behaviour, i.e. reseed from this word and stay in CHECK.
  - LOCKED: expected ← next(expected) on every word; no reseeding.
    - On mismatch: WordErrors += 1, BitErrors += popcount(RxData ^ expected), bad++.
    - On match: bad ← 0.
    - When bad reaches UNLOCK_BAD: go to SEED and pulse `LinkLost_o`.
- A mode change in any state forces SEED. A change to off forces IDLE. `Locked_o` drops on the same edge.
- Counters saturate at 2^CNT_W−1 and are never wrapped. The bit-error addition is clamped.
- `Clear_i` zeros both counters and has priority over a simultaneous increment. The FSM is unaffected.

## Timing
- Reset values: TxData 0, LFSR 7'h7F, counter 0, FSM IDLE, `Locked_o` 0, `LinkLost_o` 0, both counters 0, injection latch 0.
- `TxData_ob` is registered and updates one cycle after a `TxEn_i`=1 edge.
- The checker compares the registered RX word. Counter and `Locked_o` updates are visible 2 cycles after the RX word is presented with `RxValid_i`.
- Words with `RxValid_i`=0 are ignored. The FSM, expected word and good/bad counts all hold.
- Reset asserted mid-operation returns all state to reset values asynchronously. After release, operation resumes from IDLE or SEED according to `Mode_ib`.
- Minimum time to lock from a clean stream is LOCK_GOOD+1 valid words.

## Test plan
- Loopback (TxData→RxData, RxValid=TxEn=1), mode 1 → `Locked_o`=1 after 17 valid words. WordErrors=0 and BitErrors=0 after 1000 words.
- Loopback, mode 2, one `InjectError_i` pulse after lock → WordErrors=1, BitErrors=1, `Locked_o` stays 1.
- Mode 2 locked, RX forced to all-ones for 4 words → WordErrors=4, one `LinkLost_o` pulse, `Locked_o`=0. After loopback is restored, relock within 17 words.
- CNT_W=4, 20 injected errors while locked → WordErrors saturates at 15. Assert `Clear_i` on the same cycle as an error → counter reads 0.
- Stream with `RxValid_i` toggling 1/0 every cycle → lock after 17 valid words and no errors counted.
- Mode switch 1→2 while locked → `Locked_o`=0 on the next cycle, generator restarts from 7'h7F, relock in PRBS7. Reset asserted mid-stream → all outputs return to 0 immediately.

Source files
------------

// File: rtl/gbt_link_checker.sv
// GBT frame pattern generator (counter / PRBS7) and self-synchronising checker
// with lock hysteresis and saturating word/bit error counters.
package gbt_link_pkg;
   typedef struct packed {
      logic clk;
      logic reset;
   } ckrs_t;
endpackage

module gbt_link_checker
   import gbt_link_pkg::*;
#(
   parameter int W          = 80,
   parameter int LOCK_GOOD  = 16,
   parameter int UNLOCK_BAD = 4,
   parameter int CNT_W      = 32
) (
   input  ckrs_t            ClkRs_ix,
   input  logic [1:0]       Mode_ib,
   input  logic             TxEn_i,
   input  logic             InjectError_i,
   output logic [W-1:0]     TxData_ob,
   input  logic [W-1:0]     RxData_ib,
   input  logic             RxValid_i,
   input  logic             Clear_i,
   output logic             Locked_o,
   output logic             LinkLost_o,
   output logic [CNT_W-1:0] WordErrors_ob,
   output logic [CNT_W-1:0] BitErrors_ob
);

   localparam int GW = $clog2(LOCK_GOOD + 1);
   localparam int BW = $clog2(UNLOCK_BAD + 1);
   localparam int PW = $clog2(W + 1);
   localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;
   localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {IDLE, SEED, CHECK, LOCKED} state_t;

   // MSB is the first bit out; the last 7 bits of a word are the LFSR state after it
   function automatic logic [W-1:0] prbs_word(input logic [6:0] seed);
      logic [6:0]   s;
      logic [W-1:0] r;
      s = seed;
      r = '0;
      for (int i = W - 1; i >= 0; i--) begin
         r[i] = s[6] ^ s[5];
         s    = {s[5:0], r[i]};
      end
      return r;
   endfunction

   function automatic logic [W-1:0] nxt(input logic [W-1:0] x,
                                        input logic       cnt_mode);
      return cnt_mode ? x + W'(1) : prbs_word(x[6:0]);
   endfunction

   function automatic logic [PW-1:0] popcnt(input logic [W-1:0] x);
      logic [PW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) c = c + PW'(x[i]);
      return c;
   endfunction

   logic clk, rst;
   assign clk = ClkRs_ix.clk;
   assign rst = ClkRs_ix.reset;

   logic [1:0]   mode_q;
   logic         mode_chg, active, cnt_mode;
   logic [W-1:0] cnt_q, cnt_seed, prbs_w, gen_w, tx_q;
   logic [6:0]   lfsr_q, lfsr_seed;
   logic         inj_q, inj_any, inj_now;

   assign mode_chg  = Mode_ib != mode_q;
   assign cnt_mode  = Mode_ib == 2'd1;
   assign active    = cnt_mode || (Mode_ib == 2'd2);
   assign cnt_seed  = mode_chg ? '0 : cnt_q;
   assign lfsr_seed = mode_chg ? 7'h7F : lfsr_q;
   assign prbs_w    = prbs_word(lfsr_seed);
   assign gen_w     = !active ? '0 : (cnt_mode ? cnt_seed : prbs_w);
   assign inj_any   = inj_q | InjectError_i;
   assign inj_now   = inj_any & active;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q <= 2'd0;
         cnt_q  <= '0;
         lfsr_q <= 7'h7F;
         tx_q   <= '0;
         inj_q  <= 1'b0;
      end else begin
         mode_q <= Mode_ib;
         if (TxEn_i) begin
            tx_q   <= gen_w ^ {{(W-1){1'b0}}, inj_now};
            cnt_q  <= cnt_seed + W'(1);
            lfsr_q <= prbs_w[6:0];
            inj_q  <= inj_any & ~active;
         end else begin
            cnt_q  <= cnt_seed;
            lfsr_q <= lfsr_seed;
            inj_q  <= inj_any;
         end
      end
   end

   assign TxData_ob = tx_q;

   state_t          state_q, state_d;
   logic [W-1:0]    rx_q, exp_q, exp_d, nxt_rx, nxt_exp;
   logic            rxv_q, match, lost_q, lost_d;
   logic [GW-1:0]   good_q, good_d;
   logic [BW-1:0]   bad_q, bad_d;
   logic [CNT_W-1:0] werr_q, werr_d, berr_q, berr_d;
   logic [SW-1:0]   bsum;

   assign nxt_rx  = nxt(rx_q, cnt_mode);
   assign nxt_exp = nxt(exp_q, cnt_mode);
   assign match   = rx_q == exp_q;
   assign bsum    = SW'(berr_q) + SW'(popcnt(rx_q ^ exp_q));

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      good_d  = good_q;
      bad_d   = bad_q;
      werr_d  = werr_q;
      berr_d  = berr_q;
      lost_d  = 1'b0;
      if (mode_chg) begin
         state_d = active ? SEED : IDLE;
         good_d  = '0;
         bad_d   = '0;
         lost_d  = active && (state_q == LOCKED);
      end else if (rxv_q) begin
         unique case (state_q)
            IDLE: ;
            SEED: begin
               exp_d   = nxt_rx;
               good_d  = '0;
               state_d = CHECK;
            end
            CHECK: begin
               if (match) begin
                  exp_d  = nxt_exp;
                  good_d = good_q + GW'(1);
                  if (good_q == GW'(LOCK_GOOD - 1)) begin
                     state_d = LOCKED;
                     bad_d   = '0;
                  end
               end else begin
                  exp_d  = nxt_rx;
                  good_d = '0;
               end
            end
            LOCKED: begin
               exp_d = nxt_exp;
               if (match) begin
                  bad_d = '0;
               end else begin
                  bad_d  = bad_q + BW'(1);
                  werr_d = (werr_q == CMAX) ? CMAX : werr_q + CNT_W'(1);
                  berr_d = (bsum > SW'(CMAX)) ? CMAX : bsum[CNT_W-1:0];
                  if (bad_q == BW'(UNLOCK_BAD - 1)) begin
                     state_d = SEED;
                     lost_d  = 1'b1;
                     bad_d   = '0;
                  end
               end
            end
            default: ;
         endcase
      end
      // clear wins over an increment on the same edge
      if (Clear_i) begin
         werr_d = '0;
         berr_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q    <= '0;
         rxv_q   <= 1'b0;
         state_q <= IDLE;
         exp_q   <= '0;
         good_q  <= '0;
         bad_q   <= '0;
         werr_q  <= '0;
         berr_q  <= '0;
         lost_q  <= 1'b0;
      end else begin
         rx_q    <= RxData_ib;
         rxv_q   <= RxValid_i;
         state_q <= state_d;
         exp_q   <= exp_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         werr_q  <= werr_d;
         berr_q  <= berr_d;
         lost_q  <= lost_d;
      end
   end

   assign Locked_o      = state_q == LOCKED;
   assign LinkLost_o    = lost_q;
   assign WordErrors_ob = werr_q;
   assign BitErrors_ob  = berr_q;

endmodule

// File: tb/tb_gbt_link_checker.sv
// Bench for gbt_link_checker: TX word scoreboard plus lock, error-count,
// saturation, clear, valid-gap, mode-switch and reset scenarios.
module tb_gbt_link_checker;
   import gbt_link_pkg::*;

   localparam int W   = 80;
   localparam int CW  = 32;
   localparam int CW2 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   ckrs_t ckrs;
   assign ckrs = {clk, rst};

   logic [1:0]   mode = 2'd0;
   logic         tx_en = 1'b0, inject = 1'b0, rx_valid = 1'b0;
   logic         clear = 1'b0, lb = 1'b0;
   logic [W-1:0] rx_force = '0;
   logic [W-1:0] rx_data, tx_data, tx_data2;
   logic         locked, lost, locked2, lost2;
   logic [CW-1:0]  werr, berr;
   logic [CW2-1:0] werr2, berr2;

   assign rx_data = lb ? tx_data : rx_force;

   gbt_link_checker #(.W(W), .LOCK_GOOD(16), .UNLOCK_BAD(4), .CNT_W(CW)) dut (
      .ClkRs_ix(ckrs), .Mode_ib(mode), .TxEn_i(tx_en),
      .InjectError_i(inject), .TxData_ob(tx_data), .RxData_ib(rx_data),
      .RxValid_i(rx_valid), .Clear_i(clear), .Locked_o(locked),
      .LinkLost_o(lost), .WordErrors_ob(werr), .BitErrors_ob(berr)
   );

   gbt_link_checker #(.W(W), .LOCK_GOOD(16), .UNLOCK_BAD(4), .CNT_W(CW2)) dut2 (
      .ClkRs_ix(ckrs), .Mode_ib(mode), .TxEn_i(tx_en),
      .InjectError_i(inject), .TxData_ob(tx_data2), .RxData_ib(rx_data),
      .RxValid_i(rx_valid), .Clear_i(clear), .Locked_o(locked2),
      .LinkLost_o(lost2), .WordErrors_ob(werr2), .BitErrors_ob(berr2)
   );

   always #5 clk = ~clk;

   int vec  = 0;
   int miss = 0;

   logic [W-1:0] m_cnt  = '0;
   logic [6:0]   m_lfsr = 7'h7F;
   logic [1:0]   m_mode = 2'd0;
   logic         m_inj  = 1'b0;
   logic [W-1:0] sb[$];

   // x^7+x^6+1, first generated bit lands in the word MSB
   function automatic logic [W-1:0] prbs_ref(input logic [6:0] seed);
      logic [6:0]   s;
      logic [W-1:0] r;
      s = seed;
      for (int i = 0; i < W; i++) begin
         r[W-1-i] = s[6] ^ s[5];
         s = {s[5:0], r[W-1-i]};
      end
      return r;
   endfunction

   task automatic tick();
      logic [W-1:0] w, p, e;
      logic inj, act;
      if (!rst) begin
         if (mode != m_mode) begin
            m_cnt  = '0;
            m_lfsr = 7'h7F;
         end
         m_mode = mode;
         act = (mode == 2'd1) || (mode == 2'd2);
         inj = m_inj | inject;
         if (tx_en) begin
            p = prbs_ref(m_lfsr);
            if (mode == 2'd1) w = m_cnt;
            else if (mode == 2'd2) w = p;
            else w = '0;
            if (inj && act) begin
               w[0] = ~w[0];
               inj = 1'b0;
            end
            sb.push_back(w);
            m_cnt  = m_cnt + 1;
            m_lfsr = p[6:0];
         end
         m_inj = inj;
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         vec++;
         if (tx_data !== e) begin
            miss++;
            $display("FAIL tx_word: got %h want %h", tx_data, e);
         end
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec += 5;
      if (tx_data !== '0) begin miss++; $display("FAIL rst_tx: got %h want 0", tx_data); end
      if (locked !== 1'b0) begin miss++; $display("FAIL rst_locked: got %b want 0", locked); end
      if (lost !== 1'b0) begin miss++; $display("FAIL rst_lost: got %b want 0", lost); end
      if (werr !== '0) begin miss++; $display("FAIL rst_werr: got %0d want 0", werr); end
      if (berr !== '0) begin miss++; $display("FAIL rst_berr: got %0d want 0", berr); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_counter_lock();
      int lock_n = 0;
      mode = 2'd1; tx_en = 1'b1; rx_valid = 1'b1; lb = 1'b1;
      for (int n = 1; n <= 40 && lock_n == 0; n++) begin
         tick();
         if (locked) lock_n = n;
      end
      vec++;
      if (lock_n !== 19) begin miss++; $display("FAIL cnt_lock_cycle: got %0d want 19", lock_n); end
      repeat (1000) tick();
      vec += 3;
      if (werr !== '0) begin miss++; $display("FAIL cnt_werr: got %0d want 0", werr); end
      if (berr !== '0) begin miss++; $display("FAIL cnt_berr: got %0d want 0", berr); end
      if (locked !== 1'b1) begin miss++; $display("FAIL cnt_locked: got %b want 1", locked); end
   endtask

   task automatic test_prbs_inject();
      int lock_n = 0;
      logic held = 1'b1;
      mode = 2'd2;
      for (int n = 1; n <= 40 && lock_n == 0; n++) begin
         tick();
         if (locked) lock_n = n;
      end
      vec++;
      if (lock_n < 17 || lock_n > 21) begin miss++; $display("FAIL prbs_lock_cycle: got %0d want 17..21", lock_n); end
      pulse_clear();
      repeat (5) tick();
      inject = 1'b1;
      tick();
      inject = 1'b0;
      repeat (10) begin
         tick();
         if (!locked) held = 1'b0;
      end
      vec += 3;
      if (held !== 1'b1) begin miss++; $display("FAIL inj_held_lock: got %b want 1", held); end
      if (werr !== 32'd1) begin miss++; $display("FAIL inj_werr: got %0d want 1", werr); end
      if (berr !== 32'd1) begin miss++; $display("FAIL inj_berr: got %0d want 1", berr); end
   endtask

   task automatic test_link_loss();
      int nlost = 0, lock_n = 0;
      logic l1 = 1'b1;
      pulse_clear();
      lb = 1'b0;
      rx_force = '1;
      repeat (4) tick();
      lb = 1'b1;
      for (int n = 1; n <= 30; n++) begin
         tick();
         if (lost) nlost++;
         if (n == 1) l1 = locked;
         if (n > 1 && locked && lock_n == 0) lock_n = n;
      end
      vec += 4;
      if (l1 !== 1'b0) begin miss++; $display("FAIL loss_locked: got %b want 0", l1); end
      if (nlost !== 1) begin miss++; $display("FAIL loss_pulses: got %0d want 1", nlost); end
      if (werr !== 32'd4) begin miss++; $display("FAIL loss_werr: got %0d want 4", werr); end
      if (lock_n < 18 || lock_n > 20) begin miss++; $display("FAIL relock_cycle: got %0d want 18..20", lock_n); end
   endtask

   task automatic test_saturation();
      pulse_clear();
      repeat (20) begin
         inject = 1'b1;
         tick();
         inject = 1'b0;
         repeat (3) tick();
      end
      repeat (4) tick();
      vec += 5;
      if (werr !== 32'd20) begin miss++; $display("FAIL sat_werr32: got %0d want 20", werr); end
      if (berr !== 32'd20) begin miss++; $display("FAIL sat_berr32: got %0d want 20", berr); end
      if (werr2 !== 4'd15) begin miss++; $display("FAIL sat_werr4: got %0d want 15", werr2); end
      if (berr2 !== 4'd15) begin miss++; $display("FAIL sat_berr4: got %0d want 15", berr2); end
      if (locked2 !== 1'b1) begin miss++; $display("FAIL sat_locked: got %b want 1", locked2); end
      inject = 1'b1;
      tick();
      inject = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      repeat (4) tick();
      vec += 3;
      if (werr !== '0) begin miss++; $display("FAIL clr_prio_werr32: got %0d want 0", werr); end
      if (berr !== '0) begin miss++; $display("FAIL clr_prio_berr32: got %0d want 0", berr); end
      if (werr2 !== '0) begin miss++; $display("FAIL clr_prio_werr4: got %0d want 0", werr2); end
   endtask

   task automatic test_valid_toggle();
      int nv = 0, lk_nv = 0;
      clear = 1'b1;
      mode = 2'd1; tx_en = 1'b1; rx_valid = 1'b1;
      for (int n = 1; n <= 60; n++) begin
         if (rx_valid) nv++;
         tick();
         clear = 1'b0;
         if (locked && lk_nv == 0) lk_nv = nv;
         tx_en = ~tx_en;
         rx_valid = tx_en;
      end
      tx_en = 1'b1; rx_valid = 1'b1;
      vec += 3;
      if (lk_nv < 17 || lk_nv > 19) begin miss++; $display("FAIL gap_lock_words: got %0d want 17..19", lk_nv); end
      if (werr !== '0) begin miss++; $display("FAIL gap_werr: got %0d want 0", werr); end
      if (berr !== '0) begin miss++; $display("FAIL gap_berr: got %0d want 0", berr); end
   endtask

   task automatic test_mode_switch();
      int lock_n = 0;
      logic [W-1:0] t;
      repeat (5) tick();
      vec++;
      if (locked !== 1'b1) begin miss++; $display("FAIL sw_pre_locked: got %b want 1", locked); end
      mode = 2'd2;
      tick();
      t = tx_data;
      vec += 2;
      if (locked !== 1'b0) begin miss++; $display("FAIL sw_locked_drop: got %b want 0", locked); end
      if (t[W-1 -: 8] !== 8'h02) begin miss++; $display("FAIL sw_prbs_head: got %h want 02", t[W-1 -: 8]); end
      for (int n = 2; n <= 30 && lock_n == 0; n++) begin
         tick();
         if (locked) lock_n = n;
      end
      vec++;
      if (lock_n < 17 || lock_n > 21) begin miss++; $display("FAIL sw_relock: got %0d want 17..21", lock_n); end
   endtask

   task automatic test_reset_mid();
      int lock_n = 0;
      inject = 1'b1;
      tick();
      inject = 1'b0;
      repeat (4) tick();
      vec++;
      if (werr !== 32'd1) begin miss++; $display("FAIL mid_pre_werr: got %0d want 1", werr); end
      rst = 1'b1;
      #1;
      vec += 5;
      if (tx_data !== '0) begin miss++; $display("FAIL mid_rst_tx: got %h want 0", tx_data); end
      if (locked !== 1'b0) begin miss++; $display("FAIL mid_rst_locked: got %b want 0", locked); end
      if (lost !== 1'b0) begin miss++; $display("FAIL mid_rst_lost: got %b want 0", lost); end
      if (werr !== '0) begin miss++; $display("FAIL mid_rst_werr: got %0d want 0", werr); end
      if (berr !== '0) begin miss++; $display("FAIL mid_rst_berr: got %0d want 0", berr); end
      m_cnt = '0; m_lfsr = 7'h7F; m_mode = 2'd0; m_inj = 1'b0;
      sb.delete();
      repeat (2) tick();
      rst = 1'b0;
      for (int n = 1; n <= 40 && lock_n == 0; n++) begin
         tick();
         if (locked) lock_n = n;
      end
      vec++;
      if (lock_n !== 19) begin miss++; $display("FAIL mid_relock: got %0d want 19", lock_n); end
   endtask

   initial begin
      test_reset();
      test_counter_lock();
      test_prbs_inject();
      test_link_loss();
      test_saturation();
      test_valid_toggle();
      test_mode_switch();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
